// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: constants shared by the multicycle controller and its ALU decoder.
//   - opcode (IR[31:26]) and funct (IR[5:0]) values of the supported subset
//   - alu_ctrl encodings driven to the datapath ALU
//   - FSM state encodings (also exported on mc_ctrl.state)
//   - alu_op_e: how the decoder should derive alu_ctrl in the current state
package cpu_defs_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // FSM state encodings
    localparam logic [3:0] S_INIT      = 4'd0;
    localparam logic [3:0] S_IF        = 4'd1;
    localparam logic [3:0] S_ID        = 4'd2;
    localparam logic [3:0] S_EX_MEMADR = 4'd3;
    localparam logic [3:0] S_MEM_RD    = 4'd4;
    localparam logic [3:0] S_MEM_WR    = 4'd5;
    localparam logic [3:0] S_WB_LW     = 4'd6;
    localparam logic [3:0] S_EX_R      = 4'd7;
    localparam logic [3:0] S_WB_R      = 4'd8;
    localparam logic [3:0] S_EX_I      = 4'd9;
    localparam logic [3:0] S_WB_I      = 4'd10;
    localparam logic [3:0] S_BR        = 4'd11;
    localparam logic [3:0] S_JMP       = 4'd12;

    // AOP_NONE forces alu_ctrl to 0 in states that do not use the ALU
    typedef enum logic [2:0] {
        AOP_NONE,
        AOP_ADD,
        AOP_SUB,
        AOP_FUNCT,
        AOP_IMM
    } alu_op_e;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: op_legal = 1'b1;
            default:                           op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_dec.sv
// alu_dec: combinational ALU-control decoder.
//   alu_op   in  selects the source of the ALU function (none/add/sub/funct/imm)
//   op       in  opcode, used for I-type immediate ops
//   funct    in  function field, used for R-type ops
//   alu_ctrl out 3-bit ALU function
module alu_dec
    import cpu_defs_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = 3'b000;
        case (alu_op)
            AOP_ADD: alu_ctrl = ALU_ADD;
            AOP_SUB: alu_ctrl = ALU_SUB;
            AOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            AOP_IMM: begin
                case (op)
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = 3'b000;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control FSM with retired-instruction counter.
//   clk, rst            clock; synchronous active-low reset
//   op, funct           IR[31:26], IR[5:0]
//   zero                ALU zero flag (branch resolve)
//   mem_ready           memory access completes this cycle
//   pc_write..write_reg datapath strobes and selects
//   alu_srca/srcb/ctrl  ALU operand selects and function
//   pc_source           next-PC select
//   illegal             pulse in ID on an unrecognised opcode
//   state               current FSM state
//   retired             count of completed legal instructions (wraps)
module mc_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic             write_reg,
    output logic             alu_srca,
    output logic [1:0]       alu_srcb,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       pc_source,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    logic [3:0] state_nx;
    logic       retire;
    alu_op_e    alu_op;

    alu_dec u_alu_dec (
        .alu_op   (alu_op),
        .op       (op),
        .funct    (funct),
        .alu_ctrl (alu_ctrl)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_INIT;
            retired <= '0;
        end else begin
            state <= state_nx;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    // Next state
    always_comb begin
        state_nx = S_INIT;
        case (state)
            S_INIT: state_nx = S_IF;
            S_IF:   state_nx = mem_ready ? S_ID : S_IF;
            S_ID: begin
                case (op)
                    OP_RTYPE:                          state_nx = S_EX_R;
                    OP_LW, OP_SW:                      state_nx = S_EX_MEMADR;
                    OP_BEQ, OP_BNE:                    state_nx = S_BR;
                    OP_J:                              state_nx = S_JMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nx = S_EX_I;
                    default:                           state_nx = S_IF;
                endcase
            end
            S_EX_MEMADR: state_nx = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    state_nx = mem_ready ? S_WB_LW : S_MEM_RD;
            S_MEM_WR:    state_nx = mem_ready ? S_IF : S_MEM_WR;
            S_WB_LW:     state_nx = S_IF;
            S_EX_R:      state_nx = S_WB_R;
            S_WB_R:      state_nx = S_IF;
            S_EX_I:      state_nx = S_WB_I;
            S_WB_I:      state_nx = S_IF;
            S_BR:        state_nx = S_IF;
            S_JMP:       state_nx = S_IF;
            default:     state_nx = S_INIT;
        endcase
    end

    // Outputs: everything defaults to 0, each state raises only its own strobes
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        iord      = 1'b0;
        memtoreg  = 1'b0;
        regdst    = 1'b0;
        write_reg = 1'b0;
        alu_srca  = 1'b0;
        alu_srcb  = 2'd0;
        pc_source = 2'd0;
        illegal   = 1'b0;
        retire    = 1'b0;
        alu_op    = AOP_NONE;
        case (state)
            S_IF: begin
                mem_read = 1'b1;
                alu_srcb = 2'd1;
                alu_op   = AOP_ADD;
                // IR and PC load only on the cycle the fetch completes
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_ID: begin
                alu_srcb = 2'd3;
                alu_op   = AOP_ADD;
                illegal  = !op_legal(op);
            end
            S_EX_MEMADR: begin
                alu_srca = 1'b1;
                alu_srcb = 2'd2;
                alu_op   = AOP_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = mem_ready;
            end
            S_WB_LW: begin
                write_reg = 1'b1;
                memtoreg  = 1'b1;
                retire    = 1'b1;
            end
            S_EX_R: begin
                alu_srca = 1'b1;
                alu_op   = AOP_FUNCT;
            end
            S_WB_R: begin
                write_reg = 1'b1;
                regdst    = 1'b1;
                retire    = 1'b1;
            end
            S_EX_I: begin
                alu_srca = 1'b1;
                alu_srcb = 2'd2;
                alu_op   = AOP_IMM;
            end
            S_WB_I: begin
                write_reg = 1'b1;
                retire    = 1'b1;
            end
            S_BR: begin
                alu_srca  = 1'b1;
                alu_op    = AOP_SUB;
                pc_source = 2'd1;
                pc_write  = (op == OP_BEQ) ? zero : !zero;
                retire    = 1'b1;
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl (CNT_W=4 so counter wrap is reachable).
// The driver pushes one expected record per cycle; the monitor pops and compares
// state, the packed control word and retired on the falling edge.
module tb_mc_ctrl;

    localparam int CW = 4;

    localparam logic [3:0] T_INIT = 4'd0,  T_IF   = 4'd1,  T_ID   = 4'd2,
                           T_EXMA = 4'd3,  T_MRD  = 4'd4,  T_MWR  = 4'd5,
                           T_WBLW = 4'd6,  T_EXR  = 4'd7,  T_WBR  = 4'd8,
                           T_EXI  = 4'd9,  T_WBI  = 4'd10, T_BR   = 4'd11,
                           T_JMP  = 4'd12;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    op, funct;
    logic          zero, mem_ready;
    logic          pc_write, ir_write, mem_read, mem_write, iord;
    logic          memtoreg, regdst, write_reg, alu_srca, illegal;
    logic [1:0]    alu_srcb, pc_source;
    logic [2:0]    alu_ctrl;
    logic [3:0]    state;
    logic [CW-1:0] retired;

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .memtoreg(memtoreg), .regdst(regdst), .write_reg(write_reg),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
        .pc_source(pc_source), .illegal(illegal), .state(state),
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    st;
        logic [16:0]   cw;
        logic [CW-1:0] ret;
    } exp_t;

    exp_t          q[$];
    exp_t          e_mon;
    int            total = 0;
    int            bad = 0;
    int            fw = 0;
    logic [CW-1:0] exp_ret = '0;
    logic [16:0]   dut_cw;

    assign dut_cw = {pc_write, ir_write, mem_read, mem_write, iord, memtoreg,
                     regdst, write_reg, alu_srca, alu_srcb, alu_ctrl,
                     pc_source, illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_mon = q.pop_front();
            chk("state", 32'(state), 32'(e_mon.st));
            chk("ctrl", 32'(dut_cw), 32'(e_mon.cw));
            chk("retired", 32'(retired), 32'(e_mon.ret));
        end
    end

    function automatic logic [16:0] mk(input logic pcw, irw, mr, mw, io, m2r, rd, wr, sa,
                                       input logic [1:0] sb, input logic [2:0] ac,
                                       input logic [1:0] ps, input logic ill);
        return {pcw, irw, mr, mw, io, m2r, rd, wr, sa, sb, ac, ps, ill};
    endfunction

    // One cycle: drive inputs, record what the DUT must show this cycle
    task automatic step(input logic r, input logic z, input logic [3:0] st, input logic [16:0] cw);
        exp_t e;
        mem_ready = r;
        zero      = z;
        e.st  = st;
        e.cw  = cw;
        e.ret = exp_ret;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic ill);
        repeat (fw) step(1'b0, 1'b0, T_IF, mk(0,0,1,0,0,0,0,0,0,2'd1,3'b010,2'd0,0));
        step(1'b1, 1'b0, T_IF, mk(1,1,1,0,0,0,0,0,0,2'd1,3'b010,2'd0,0));
        step(1'b1, 1'b0, T_ID, mk(0,0,0,0,0,0,0,0,0,2'd3,3'b010,2'd0,ill));
    endtask

    task automatic do_r(input logic [5:0] fn, input logic [2:0] ac);
        op = 6'b000000; funct = fn;
        fetch_decode(1'b0);
        step(1'b1, 1'b0, T_EXR, mk(0,0,0,0,0,0,0,0,1,2'd0,ac,2'd0,0));
        step(1'b1, 1'b0, T_WBR, mk(0,0,0,0,0,0,1,1,0,2'd0,3'b000,2'd0,0));
        exp_ret++;
    endtask

    task automatic do_i(input logic [5:0] o, input logic [2:0] ac);
        op = o; funct = 6'b111111;
        fetch_decode(1'b0);
        step(1'b1, 1'b0, T_EXI, mk(0,0,0,0,0,0,0,0,1,2'd2,ac,2'd0,0));
        step(1'b1, 1'b0, T_WBI, mk(0,0,0,0,0,0,0,1,0,2'd0,3'b000,2'd0,0));
        exp_ret++;
    endtask

    task automatic do_lw(input int nw);
        op = 6'b100011; funct = 6'b100010;
        fetch_decode(1'b0);
        step(1'b1, 1'b0, T_EXMA, mk(0,0,0,0,0,0,0,0,1,2'd2,3'b010,2'd0,0));
        repeat (nw) step(1'b0, 1'b0, T_MRD, mk(0,0,1,0,1,0,0,0,0,2'd0,3'b000,2'd0,0));
        step(1'b1, 1'b0, T_MRD, mk(0,0,1,0,1,0,0,0,0,2'd0,3'b000,2'd0,0));
        step(1'b1, 1'b0, T_WBLW, mk(0,0,0,0,0,1,0,1,0,2'd0,3'b000,2'd0,0));
        exp_ret++;
    endtask

    task automatic do_sw_front(input int nw);
        op = 6'b101011; funct = 6'b000000;
        fetch_decode(1'b0);
        step(1'b1, 1'b0, T_EXMA, mk(0,0,0,0,0,0,0,0,1,2'd2,3'b010,2'd0,0));
        repeat (nw) step(1'b0, 1'b0, T_MWR, mk(0,0,0,1,1,0,0,0,0,2'd0,3'b000,2'd0,0));
    endtask

    task automatic do_sw(input int nw);
        do_sw_front(nw);
        step(1'b1, 1'b0, T_MWR, mk(0,0,0,1,1,0,0,0,0,2'd0,3'b000,2'd0,0));
        exp_ret++;
    endtask

    task automatic do_br(input logic [5:0] o, input logic z);
        logic taken;
        op = o; funct = 6'b100000;
        taken = (o == 6'b000100) ? z : !z;
        fetch_decode(1'b0);
        step(1'b1, z, T_BR, mk(taken,0,0,0,0,0,0,0,1,2'd0,3'b110,2'd1,0));
        exp_ret++;
    endtask

    task automatic do_j();
        op = 6'b000010; funct = 6'b000000;
        fetch_decode(1'b0);
        step(1'b1, 1'b0, T_JMP, mk(1,0,0,0,0,0,0,0,0,2'd0,3'b000,2'd2,0));
        exp_ret++;
    endtask

    task automatic do_ill(input logic [5:0] o);
        op = o; funct = 6'b000000;
        fetch_decode(1'b1);
    endtask

    // Reset already sampled at the preceding edge; DUT now in INIT
    task automatic after_reset();
        rst = 1'b1;
        exp_ret = '0;
        step(1'b1, 1'b0, T_INIT, 17'd0);
    endtask

    initial begin
        rst = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        after_reset();

        do_r(6'b100000, 3'b010);
        do_r(6'b100010, 3'b110);
        do_r(6'b100100, 3'b000);
        do_r(6'b100101, 3'b001);
        do_r(6'b101010, 3'b111);
        do_r(6'b000111, 3'b010);
        do_i(6'b001000, 3'b010);
        do_i(6'b001100, 3'b000);
        do_i(6'b001101, 3'b001);
        do_i(6'b001010, 3'b111);
        do_lw(3);
        do_lw(0);
        do_sw(0);
        do_sw(2);
        do_br(6'b000100, 1'b1);
        do_br(6'b000101, 1'b1);
        do_br(6'b000100, 1'b0);
        do_br(6'b000101, 1'b0);
        do_j();
        do_ill(6'b111111);
        do_ill(6'b000011);
        fw = 2;
        do_r(6'b100000, 3'b010);
        fw = 0;

        // Reset while stalled in MEM_WR: the stall cycle still shows MEM_WR
        do_sw_front(2);
        rst = 1'b0;
        step(1'b0, 1'b0, T_MWR, mk(0,0,0,1,1,0,0,0,0,2'd0,3'b000,2'd0,0));
        after_reset();

        // 15 instructions, then a jump that wraps the 4-bit counter
        for (int i = 0; i < 15; i++) begin
            case (i % 3)
                0:       do_j();
                1:       do_r(6'b100101, 3'b001);
                default: do_br(6'b000100, 1'b1);
            endcase
        end
        do_j();
        step(1'b0, 1'b0, T_IF, mk(0,0,1,0,0,0,0,0,0,2'd1,3'b010,2'd0,0));

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 op  input  6  opcode, IR[31:26], valid from state ID onward.
REQ-005 funct  input  6  function field, IR[5:0]; passed to ALU decode.
REQ-006 zero  input  1  ALU zero flag, sampled in BR.
REQ-007 mem_ready  input  1  memory completion handshake; 1 = access done this cycle.
REQ-008 pc_write, ir_write, mem_read, mem_write, iord  output  1 each  PC/IR load, memory strobes, address select (1 = ALUOut).
REQ-009 memtoreg, regdst, write_reg  output  1 each  register-file write-data select (1 = DR), dest select (1 = rd), write enable.
REQ-010 alu_srca  output  1  (0 = PC, 1 = A); alu_srcb  output  2  (0 = B, 1 = 4, 2 = sign-ext imm, 3 = sign-ext imm<<2).
REQ-011 alu_ctrl  output  3  ALU function; pc_source  output  2  (0 = ALU, 1 = ALUOut, 2 = jump target).
REQ-012 illegal  output  1  one-cycle pulse on unrecognised opcode.
REQ-013 state  output  4  current state encoding; retired  output  CNT_W  retired-instruction count.

Function
REQ-014 States: INIT, IF, ID, EX_MEMADR, MEM_RD, MEM_WR, WB_LW, EX_R, WB_R, EX_I, WB_I, BR, JMP.
REQ-015 All outputs not named active for a state SHALL be 0 in that state.
REQ-016 INIT: all outputs 0; next = IF.
REQ-017 IF: mem_read=1, iord=0, alu_srca=0, alu_srcb=1, add; ir_write and pc_write SHALL equal mem_ready; stay in IF while mem_ready=0, else go to ID.
REQ-018 ID: alu_srca=0, alu_srcb=3, add; next by op: 000000->EX_R; 100011/101011->EX_MEMADR; 000100/000101->BR; 000010->JMP; 001000/001100/001101/001010->EX_I; any other -> IF with illegal=1 for that cycle.
REQ-019 EX_MEMADR: alu_srca=1, alu_srcb=2, add; lw->MEM_RD, sw->MEM_WR.
REQ-020 MEM_RD: mem_read=1, iord=1; stall until mem_ready=1, then WB_LW. MEM_WR: mem_write=1, iord=1; stall until mem_ready=1, then IF.
REQ-021 WB_LW: write_reg=1, memtoreg=1, regdst=0; next IF.
REQ-022 EX_R: alu_srca=1, alu_srcb=0, alu_ctrl from funct (add 100000->010, sub 100010->110, and 100100->000, or 100101->001, slt 101010->111, other->010); next WB_R.
REQ-023 WB_R: write_reg=1, regdst=1, memtoreg=0; next IF.
REQ-024 EX_I: alu_srca=1, alu_srcb=2; alu_ctrl addi->010, andi->000, ori->001, slti->111; next WB_I. WB_I: write_reg=1, regdst=0, memtoreg=0; next IF.
REQ-025 BR: alu_srca=1, alu_srcb=0, sub, pc_source=1; pc_write = zero for 000100, ~zero for 000101; next IF.
REQ-026 JMP: pc_write=1, pc_source=2; next IF.
REQ-027 Latency with mem_ready held 1: R/I-type 4 cycles, lw 5, sw 4, beq/bne/j 3.
REQ-028 retired increments by 1 on the final cycle of each legal instruction (WB_LW, MEM_WR with mem_ready=1, WB_R, WB_I, BR, JMP); wraps to 0 at 2^CNT_W-1; illegal opcodes do not count.
REQ-029 write_reg and mem_write SHALL never be 1 in the same cycle; pc_write SHALL never be 1 outside IF, BR, JMP.

Reset
REQ-030 rst=0 at a clock edge: state=INIT, retired=0, regardless of current state (including mid-stall in IF/MEM_RD/MEM_WR); outputs SHALL be 0 for the cycle following that edge.
REQ-031 First cycle after rst returns to 1 is INIT; IF follows.

Structure
REQ-032 Opcode, funct, state-encoding and alu_ctrl constants SHALL live in shared package cpu_defs_pkg.
REQ-033 funct/opcode-to-alu_ctrl decode SHALL be sub-module alu_dec; FSM and counter stay in mc_ctrl.

Verification
REQ-034 Reset then op=000000, funct=100000, mem_ready=1 -> states INIT,IF,ID,EX_R,WB_R; write_reg=1, regdst=1 in WB_R; retired=1.
REQ-035 lw (op=100011) with mem_ready=0 for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_read=1 throughout, write_reg=1 and memtoreg=1 only in WB_LW.
REQ-036 beq with zero=1 -> pc_write=1, pc_source=1 in BR; bne with zero=1 -> pc_write=0; both return to IF, retired +1 each.
REQ-037 op=111111 -> illegal=1 for one cycle in ID, next state IF, retired unchanged.
REQ-038 rst=0 asserted during MEM_WR stall -> next cycle state=INIT, mem_write=0, retired=0.
REQ-039 Preload retired near max (CNT_W=4, 15 instructions then j) -> retired wraps 15->0.
